// File: rtl/mcu_port_select.sv
// rtl/mcu_port_select.sv - N-way MCU SPI port selector with activity detection, guard and idle revert
module mcu_port_select #(
  parameter int N_PORTS      = 2,
  parameter int DEFAULT_PORT = 0,
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 4,
  parameter int GUARD_CYCLES = 8,
  parameter int IDLE_TIMEOUT = 0,
  parameter int BROADCAST    = 1,
  localparam int SEL_W       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic               clk32,
  input  logic               reset_n,
  input  logic               lock,
  input  logic [N_PORTS-1:0] port_sclk,
  input  logic [N_PORTS-1:0] port_csn,
  input  logic [N_PORTS-1:0] port_mosi,
  output logic [N_PORTS-1:0] port_miso,
  output logic [N_PORTS-1:0] port_intn,
  output logic               mcu_sclk,
  output logic               mcu_csn,
  output logic               mcu_mosi,
  input  logic               core_miso,
  input  logic               core_intn,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_stable,
  output logic               switched
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int GCW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam int TCW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [SEL_W-1:0] DEF_SEL    = SEL_W'(DEFAULT_PORT);
  localparam logic [FCW-1:0]   FILT_MAX   = FCW'(FILTER_LEN);
  localparam logic [GCW-1:0]   GUARD_LAST = GCW'(GUARD_CYCLES - 1);
  localparam logic [TCW-1:0]   IDLE_LAST  = TCW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam bit               TIMEOUT_EN = (IDLE_TIMEOUT > 0);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    ACTIVE    = 2'd1,
    GUARD     = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [GCW-1:0]         gcnt_q, gcnt_d;
  logic [TCW-1:0]         tcnt_q, tcnt_d;
  logic                   switched_q, switched_d;

  logic [SYNC_STAGES-1:0] sync_q [N_PORTS];
  logic [FCW-1:0]         filt_q [N_PORTS];
  logic [N_PORTS-1:0]     csn_s;
  logic [N_PORTS-1:0]     act;
  logic                   cand_valid;
  logic [SEL_W-1:0]       cand;
  logic                   csn_sel;
  logic                   forced;

  // Synchronise each port csn into clk32; chains idle high so reset never looks like activity
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PORTS; i++) sync_q[i] <= '1;
    end else begin
      for (int i = 0; i < N_PORTS; i++) sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], port_csn[i]};
    end
  end

  // Glitch filter: saturating count of consecutive synced-low cycles per port
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_PORTS; i++) filt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (csn_s[i]) filt_q[i] <= '0;
        else if (filt_q[i] != FILT_MAX) filt_q[i] <= filt_q[i] + FCW'(1);
      end
    end
  end

  // Per-port synced csn, activity flags, and lowest-index active port other than the selected one
  always_comb begin
    cand_valid = 1'b0;
    cand       = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      csn_s[i] = sync_q[i][SYNC_STAGES-1];
      act[i]   = (filt_q[i] == FILT_MAX);
    end
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (act[i] && (SEL_W'(i) != sel_q)) begin
        cand_valid = 1'b1;
        cand       = SEL_W'(i);
      end
    end
    csn_sel = csn_s[sel_q];
  end

  // Selection state, guard and idle counters, switched pulse
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= WAIT_IDLE;
      sel_q      <= DEF_SEL;
      gcnt_q     <= '0;
      tcnt_q     <= '0;
      switched_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gcnt_q     <= gcnt_d;
      tcnt_q     <= tcnt_d;
      switched_q <= switched_d;
    end
  end

  // Next-state: switch only between frames of the selected port, candidate beats idle revert
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gcnt_d     = gcnt_q;
    tcnt_d     = tcnt_q;
    switched_d = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (csn_sel) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (!lock && cand_valid && csn_sel) begin
          sel_d      = cand;
          switched_d = 1'b1;
          state_d    = GUARD;
          gcnt_d     = '0;
          tcnt_d     = '0;
        end else if (TIMEOUT_EN && (sel_q != DEF_SEL) && !lock) begin
          if (!csn_sel) begin
            tcnt_d = '0;
          end else if (tcnt_q == IDLE_LAST) begin
            sel_d      = DEF_SEL;
            switched_d = 1'b1;
            state_d    = GUARD;
            gcnt_d     = '0;
            tcnt_d     = '0;
          end else begin
            tcnt_d = tcnt_q + TCW'(1);
          end
        end
      end
      GUARD: begin
        tcnt_d = '0;
        if (gcnt_q == GUARD_LAST) state_d = WAIT_IDLE;
        else gcnt_d = gcnt_q + GCW'(1);
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // Pin routing straight from the raw pads; core is held off outside ACTIVE
  always_comb begin
    forced   = (state_q != ACTIVE);
    mcu_csn  = forced | port_csn[sel_q];
    mcu_sclk = !forced & port_sclk[sel_q];
    mcu_mosi = !forced & port_mosi[sel_q];
    for (int i = 0; i < N_PORTS; i++) begin
      if ((BROADCAST != 0) || (SEL_W'(i) == sel_q)) begin
        port_miso[i] = core_miso;
        port_intn[i] = core_intn;
      end else begin
        port_miso[i] = 1'b0;
        port_intn[i] = 1'b1;
      end
    end
  end

  assign sel        = sel_q;
  assign sel_stable = (state_q == ACTIVE);
  assign switched   = switched_q;

endmodule

// File: tb/tb_mcu_port_select.sv
// tb/tb_mcu_port_select.sv - self-checking bench for mcu_port_select
module tb_mcu_port_select;

  localparam int N   = 3;
  localparam int DEF = 0;
  localparam int S   = 2;
  localparam int F   = 4;
  localparam int G   = 8;
  localparam int TO  = 60;
  localparam int D   = S + F;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         lock;
  logic [N-1:0] p_sclk, p_csn, p_mosi, p_miso, p_intn;
  logic         mcu_sclk, mcu_csn, mcu_mosi;
  logic         core_miso, core_intn;
  logic [1:0]   sel;
  logic         sel_stable, switched;

  always #5 clk = ~clk;

  mcu_port_select #(
    .N_PORTS(N), .DEFAULT_PORT(DEF), .SYNC_STAGES(S), .FILTER_LEN(F),
    .GUARD_CYCLES(G), .IDLE_TIMEOUT(TO), .BROADCAST(1)
  ) dut (
    .clk32(clk), .reset_n(rst_n), .lock(lock),
    .port_sclk(p_sclk), .port_csn(p_csn), .port_mosi(p_mosi),
    .port_miso(p_miso), .port_intn(p_intn),
    .mcu_sclk(mcu_sclk), .mcu_csn(mcu_csn), .mcu_mosi(mcu_mosi),
    .core_miso(core_miso), .core_intn(core_intn),
    .sel(sel), .sel_stable(sel_stable), .switched(switched)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference: raw csn history per port (index 0 = most recent sample) and a plain selection record
  bit hist [N][D];
  int m_sel, m_idle, m_guard_left;
  bit m_wait, m_sw;

  function automatic bit synced(int p);
    return hist[p][S-1];
  endfunction

  function automatic bit hot(int p);
    for (int k = S; k < D; k++) if (hist[p][k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_sel = DEF; m_idle = 0; m_guard_left = 0; m_wait = 1'b1; m_sw = 1'b0;
    for (int p = 0; p < N; p++) for (int k = 0; k < D; k++) hist[p][k] = 1'b1;
  endfunction

  function automatic void enter_guard(int p);
    m_sel = p; m_sw = 1'b1; m_guard_left = G; m_idle = 0;
  endfunction

  function automatic void model_edge();
    int c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_sw = 1'b0;
    if (m_wait) begin
      if (synced(m_sel)) m_wait = 1'b0;
    end else if (m_guard_left > 0) begin
      m_guard_left--;
      m_idle = 0;
      if (m_guard_left == 0) m_wait = 1'b1;
    end else begin
      c = -1;
      for (int i = N - 1; i >= 0; i--) if (i != m_sel && hot(i)) c = i;
      if (!lock && c >= 0 && synced(m_sel)) enter_guard(c);
      else if (TO > 0 && m_sel != DEF && !lock) begin
        if (!synced(m_sel)) m_idle = 0;
        else begin
          m_idle++;
          if (m_idle == TO) enter_guard(DEF);
        end
      end
    end
    for (int p = 0; p < N; p++) begin
      for (int k = D - 1; k > 0; k--) hist[p][k] = hist[p][k-1];
      hist[p][0] = p_csn[p];
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit st;
    st = !m_wait && (m_guard_left == 0);
    chk("sel", 32'(sel), 32'(m_sel));
    chk("sel_stable", 32'(sel_stable), 32'(st));
    chk("switched", 32'(switched), 32'(m_sw));
    chk("mcu_csn", 32'(mcu_csn), 32'(st ? p_csn[m_sel] : 1'b1));
    chk("mcu_sclk", 32'(mcu_sclk), 32'(st ? p_sclk[m_sel] : 1'b0));
    chk("mcu_mosi", 32'(mcu_mosi), 32'(st ? p_mosi[m_sel] : 1'b0));
    chk("port_miso", 32'(p_miso), 32'({N{core_miso}}));
    chk("port_intn", 32'(p_intn), 32'({N{core_intn}}));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_switch(input int limit, output int k);
    k = 0;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (switched === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    steps(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int k, cnt;
    lock = 1'b0; p_csn = '1; p_sclk = '0; p_mosi = '0;
    core_miso = 1'b0; core_intn = 1'b1;
    do_reset();

    // Reset release: ACTIVE on default port after SYNC_STAGES+1 cycles
    steps(S + 1);
    chk("stable_after_reset", 32'(sel_stable), 32'd1);

    // Port 0 frame mirrors through
    p_csn[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p_sclk = 3'($urandom); p_mosi = 3'($urandom);
      core_miso = 1'($urandom); core_intn = 1'($urandom);
      step();
    end
    p_csn[0] = 1'b1; p_sclk = '0; p_mosi = '0;
    steps(4);

    // Port 1 becomes active: switch latency from the falling edge
    p_csn[1] = 1'b0;
    wait_switch(20, k);
    chk("switch_latency", 32'(k), 32'(S + F + 1));
    chk("sel_after_switch", 32'(sel), 32'd1);
    steps(3);
    p_csn[1] = 1'b1;
    steps(20);

    // Port 1 frame passes through, then the idle count restarts from its end
    p_csn[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p_sclk[1] = 1'($urandom); p_mosi[1] = 1'($urandom);
      step();
    end
    p_csn[1] = 1'b1; p_sclk = '0; p_mosi = '0;
    wait_switch(150, k);
    chk("timeout_latency", 32'(k), 32'(TO + S));
    chk("sel_after_timeout", 32'(sel), 32'(DEF));
    steps(12);

    // Short glitch on port 1 never switches
    cnt = 0;
    p_csn[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin step(); if (switched === 1'b1) cnt++; end
    p_csn[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin step(); if (switched === 1'b1) cnt++; end
    chk("glitch_no_switch", 32'(cnt), 32'd0);
    chk("sel_after_glitch", 32'(sel), 32'd0);

    // Port 0 mid-frame blocks the switch until its csn rises
    p_csn[0] = 1'b0;
    steps(3);
    p_csn[1] = 1'b0;
    steps(15);
    chk("no_switch_midframe", 32'(sel), 32'd0);
    p_csn[0] = 1'b1;
    wait_switch(10, k);
    chk("switch_after_frame", 32'(k), 32'(S + 1));
    steps(4);
    p_csn[1] = 1'b1;
    wait_switch(150, k);
    chk("revert_after_midframe", 32'(sel), 32'(DEF));
    steps(12);

    // Lock holds the selection; releasing it lets the switch through at once
    lock = 1'b1;
    p_csn[1] = 1'b0;
    steps(15);
    chk("locked_sel", 32'(sel), 32'd0);
    lock = 1'b0;
    wait_switch(5, k);
    chk("unlock_switch", 32'(k), 32'd1);
    p_csn[1] = 1'b1;
    steps(4);
    wait_switch(150, k);
    chk("revert_after_lock", 32'(sel), 32'(DEF));
    steps(12);

    // Randomised traffic with a mid-run reset
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < N; p++) if ($urandom_range(7) == 0) p_csn[p] = ~p_csn[p];
      p_sclk = 3'($urandom); p_mosi = 3'($urandom);
      core_miso = 1'($urandom); core_intn = 1'($urandom);
      if ($urandom_range(31) == 0) lock = ~lock;
      if (i == 300) do_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
